// File: rtl/demux_1_to_100_fill_pkg.sv
// Shared constants and state encoding for the 1-to-100 lane fill demux.
package demux_1_to_100_fill_pkg;

  localparam int unsigned NUM_LANES = 100;
  localparam int unsigned SEL_WIDTH = 7;

  // Lane select uses the 100:1 readback mux convention: 1-based, 0 = no lane.
  localparam logic [SEL_WIDTH-1:0] SEL_NONE  = 7'd0;
  localparam logic [SEL_WIDTH-1:0] SEL_FIRST = 7'd1;
  localparam logic [SEL_WIDTH-1:0] SEL_LAST  = 7'd100;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage : demux_1_to_100_fill_pkg

// File: rtl/demux_1_to_100_fill_if.sv
// Word-in / frame-out bus of the lane fill demux.
interface demux_1_to_100_fill_if
  import demux_1_to_100_fill_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                              flush;
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH-1:0]             in_data;
  logic [SEL_WIDTH-1:0]              sel;
  logic [NUM_LANES*DATA_WIDTH-1:0]   out_flat;
  logic                              frame_valid;
  logic                              out_ready;

  // Producer/consumer side.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, sel, out_flat, frame_valid
  );

  // Demux side.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, sel, out_flat, frame_valid
  );

endinterface : demux_1_to_100_fill_if

// File: rtl/demux_1_to_100_fill_lane_index_counter.sv
// Lane index counter: resets/loads to the first lane, increments, flags lane 100.
module lane_index_counter
  import demux_1_to_100_fill_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_clr,
  input  logic                 i_inc,
  output logic [SEL_WIDTH-1:0] o_count,
  output logic                 o_last_c
);

  logic [SEL_WIDTH-1:0] r_count;

  // Load to first lane has priority over park-at-none and increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= SEL_FIRST;
    end else if (i_load) begin
      r_count <= SEL_FIRST;
    end else if (i_clr) begin
      r_count <= SEL_NONE;
    end else if (i_inc) begin
      r_count <= r_count + SEL_WIDTH'(1);
    end
  end

  assign o_count  = r_count;
  assign o_last_c = (r_count == SEL_LAST);

endmodule : lane_index_counter

// File: rtl/demux_1_to_100_fill.sv
// Demultiplexes a word stream into 100 registered lanes and holds each full frame
// until the consumer acknowledges it.
module demux_1_to_100_fill #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_LANES  = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_1_to_100_fill_if.slave  bus
);

  import demux_1_to_100_fill_pkg::*;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_in_ready;
  logic                  r_frame_valid;
  logic                  w_accept;
  logic                  w_cnt_load;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic [SEL_WIDTH-1:0]  w_sel;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] r_lanes [NUM_LANES];

  lane_index_counter u_lane_index_counter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_cnt_load),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_cnt_inc),
    .o_count  (w_sel),
    .o_last_c (w_sel_last)
  );

  // State register; handshake outputs are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FILL;
      r_in_ready    <= 1'b1;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_in_ready    <= (w_state_nxt == ST_FILL);
      r_frame_valid <= (w_state_nxt == ST_HOLD);
    end
  end

  // Next state and counter control; flush overrides acceptance and release.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_FILL;
      w_cnt_load  = 1'b1;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (bus.in_valid) begin
            w_accept = 1'b1;
            if (w_sel_last) begin
              w_state_nxt = ST_HOLD;
              w_cnt_clr   = 1'b1;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            w_state_nxt = ST_FILL;
            w_cnt_load  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_FILL;
          w_cnt_load  = 1'b1;
        end
      endcase
    end
  end

  // Lane storage: write enable decoded from the current select; cleared only by reset.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (rst) begin
        r_lanes[k] <= '0;
      end else if (w_accept && (w_sel == SEL_WIDTH'(k + 1))) begin
        r_lanes[k] <= bus.in_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_flat
    assign bus.out_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_lanes[g];
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.frame_valid = r_frame_valid;
  assign bus.sel         = w_sel;

endmodule : demux_1_to_100_fill

// File: doc/demux_1_to_100_fill.md
DEMUX_1_TO_100_FILL -- requirements
Module: demux_1_to_100_fill

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, lane word width in bits.
REQ-002 Parameter: NUM_LANES, default 100, fixed; other values unsupported.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  abandons the partial frame; synchronous.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 in_data  input  DATA_WIDTH  word for the current lane.
REQ-010 sel  output  7  index of the lane the next accepted word writes, 1..100; 0 only during HOLD.
REQ-011 out_flat  output  100*DATA_WIDTH  lane k (1..100) occupies bits [k*DATA_WIDTH-1 : (k-1)*DATA_WIDTH].
REQ-012 frame_valid  output  1  all 100 lanes hold a complete frame.
REQ-013 out_ready  input  1  consumer acknowledges the frame.

Function
REQ-014 Two states: FILL and HOLD.
REQ-015 A word is accepted on a clock edge where in_valid=1 and in_ready=1.
REQ-016 In FILL: in_ready=1 and frame_valid=0; each accepted word writes lane sel, and sel then increments by 1.
REQ-017 In FILL, an accepted word at sel=100 moves the block to HOLD, with sel=0 and frame_valid=1 on the next cycle (1-cycle latency).
REQ-018 In HOLD: in_ready=0 and frame_valid=1; all lanes are frozen.
REQ-019 A HOLD cycle with out_ready=1 returns the block to FILL with sel=1 next cycle; in_valid is ignored in that cycle.
REQ-020 In FILL, out_ready is ignored.
REQ-021 Lane registers keep their value until overwritten; lanes are never cleared outside reset.
REQ-022 flush=1 forces FILL with sel=1 next cycle; no word is accepted that cycle.
REQ-023 flush has priority over acceptance and over out_ready.
REQ-024 flush in HOLD discards the frame (frame_valid=0 next cycle).
REQ-025 In FILL, in_valid=0 stalls: sel and lanes are unchanged.
REQ-026 out_flat is driven only by registers, with no combinational path from inputs.
REQ-027 sel encoding matches the 100:1 mux select convention (1-based, 0 = no lane), so sel and out_flat can drive that mux directly for readback.

Reset
REQ-028 rst=1 takes effect on the clock edge.
REQ-029 Values after reset: FILL state, sel=1, in_ready=1, frame_valid=0, out_flat=0.
REQ-030 rst has priority over flush and all other inputs.
REQ-031 rst in mid-frame or in HOLD discards all lane contents.

Structure
REQ-032 The shared package holds: NUM_LANES=100, SEL_WIDTH=7, SEL_NONE=0, SEL_FIRST=1, SEL_LAST=100, and the FILL/HOLD state encoding.
REQ-033 One sub-module, lane_index_counter: a 7-bit counter with load-to-1, increment, and terminal flag at 100.
REQ-034 Lane write enables are decoded inline from sel.

Verification
REQ-035 Full frame: reset, then feed 100 words 1..100 back-to-back with out_ready=0 -> frame_valid=1 on the cycle after word 100; lane k = k; in_ready=0; sel=0.
REQ-036 Handshake: in HOLD, assert out_ready=1 for 1 cycle with in_valid=1 and data 0xAA -> next cycle FILL, sel=1, lane 1 unchanged; 0xAA is not accepted.
REQ-037 Bubbles: feed words with in_valid toggling every cycle -> 100 accepts complete the frame; sel increments only on accepts.
REQ-038 Flush: accept 37 words, pulse flush together with in_valid=1 -> word not accepted; sel=1; lanes 1..37 keep the old values until rewritten.
REQ-039 Reset mid-HOLD: rst=1 for 1 cycle -> frame_valid=0; out_flat=0; sel=1; in_ready=1.
REQ-040 Readback: connect sel and out_flat to the 100:1 mux and drive its select 1..100 after a frame -> the mux returns the words in order; select 0 returns 0.
